// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit.
// The WIDTH-bit carry chain is cut into STAGES chunks of CW = WIDTH/STAGES
// bits, and each chunk is added in its own register stage. Operand chunks
// that have not been added yet travel down the pipe right-aligned, so every
// stage always adds the low CW bits of its operand registers. Finished
// result chunks accumulate in a per-stage sum register.
//
// Handshake: a bundle moves from one side to the other only when the
// sender's valid and the receiver's ready are both high at a rising clock
// edge. The whole pipe advances as one unit whenever the output register is
// empty or being drained (advance = ~out_valid | out_ready). in_ready is
// that same advance signal, so it is combinational from out_ready.
//
// Legal configurations require WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   // Per-stage registers: valid bit, chunk carry, remaining operand bits,
   // operand MSBs for the overflow test, and the partial result.
   logic             v_q   [STAGES];
   logic             c_q   [STAGES];
   logic             am_q  [STAGES];
   logic             bm_q  [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bb_q  [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic             ovf_q;

   logic             v_d   [STAGES];
   logic             c_d   [STAGES];
   logic             am_d  [STAGES];
   logic             bm_d  [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] bb_d  [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic             ovf_d;

   // Inputs seen by each stage (port side for stage 0, previous stage otherwise).
   logic             v_src  [STAGES];
   logic             c_src  [STAGES];
   logic             am_src [STAGES];
   logic             bm_src [STAGES];
   logic [WIDTH-1:0] a_src  [STAGES];
   logic [WIDTH-1:0] bb_src [STAGES];
   logic [WIDTH-1:0] s_src  [STAGES];

   logic [WIDTH-1:0] bb_in;
   logic             c0_in;
   logic [CW:0]      chunk_sum;
   logic             advance;

   // Subtraction is a + ~b + ~cin, so the core only ever adds.
   assign bb_in = sub ? ~b : b;
   assign c0_in = sub ? ~cin : cin;

   assign advance   = ~v_q[STAGES-1] | out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];
   assign y         = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

   // Next-state for every stage: add one chunk, shift the operands along.
   always_comb begin
      v_src[0]  = in_valid;
      c_src[0]  = c0_in;
      am_src[0] = a[WIDTH-1];
      bm_src[0] = bb_in[WIDTH-1];
      a_src[0]  = a;
      bb_src[0] = bb_in;
      s_src[0]  = '0;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k]  = v_q[k-1];
         c_src[k]  = c_q[k-1];
         am_src[k] = am_q[k-1];
         bm_src[k] = bm_q[k-1];
         a_src[k]  = a_q[k-1];
         bb_src[k] = bb_q[k-1];
         s_src[k]  = s_q[k-1];
      end
      chunk_sum = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk_sum = {1'b0, a_src[k][CW-1:0]} + {1'b0, bb_src[k][CW-1:0]}
                   + {{CW{1'b0}}, c_src[k]};
         v_d[k]  = v_src[k];
         c_d[k]  = chunk_sum[CW];
         am_d[k] = am_src[k];
         bm_d[k] = bm_src[k];
         a_d[k]  = a_src[k] >> CW;
         bb_d[k] = bb_src[k] >> CW;
         s_d[k]  = s_src[k];
         s_d[k][k*CW +: CW] = chunk_sum[CW-1:0];
      end
      // Signed overflow: like-signed operands producing an opposite-signed sum.
      ovf_d = (am_src[STAGES-1] == bm_src[STAGES-1]) &&
              (s_d[STAGES-1][WIDTH-1] != am_src[STAGES-1]);
   end

   // Pipeline registers: flush on reset, shift together on advance, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            am_q[k] <= 1'b0;
            bm_q[k] <= 1'b0;
            a_q[k]  <= '0;
            bb_q[k] <= '0;
            s_q[k]  <= '0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]  <= v_d[k];
            c_q[k]  <= c_d[k];
            am_q[k] <= am_d[k];
            bm_q[k] <= bm_d[k];
            a_q[k]  <= a_d[k];
            bb_q[k] <= bb_d[k];
            s_q[k]  <= s_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=32, STAGES=4).
// Expected results are {ovf, cout, y}, pushed when a bundle is accepted and
// popped by an independent monitor whenever a result is transferred.
module tb_pipelined_addsub;

   localparam int W  = 32;
   localparam int S  = 4;
   localparam int EW = W + 2;
   localparam int NV = 12;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         cout;
   logic         ovf;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   // Directed vectors with hand-computed {ovf, cout, y}.
   logic [W-1:0]  va [NV];
   logic [W-1:0]  vb [NV];
   logic          vc [NV];
   logic          vs [NV];
   logic [EW-1:0] ve [NV];

   pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Clock and global watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, expv);
   endtask

   // Reference model built from plain wide arithmetic.
   function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
      logic [W:0]   ext;
      logic [W-1:0] r;
      logic         co;
      logic         ov;
      if (!ms) begin
         ext = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
         r   = ext[W-1:0];
         co  = ext[W];
         ov  = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
      end else begin
         r  = ma - mb - {{(W-1){1'b0}}, mc};
         co = ({1'b0, ma} >= ({1'b0, mb} + {{W{1'b0}}, mc}));
         ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
      end
      return {ov, co, r};
   endfunction

   // Drive one bundle; returns whether in_ready was high on the first try.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                       input logic ts, input logic [EW-1:0] te, output logic first_rdy);
      int n;
      a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      first_rdy = in_ready;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) exp_q.push_back(te);
      else check("send_timeout", EW'(in_ready), EW'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check(name, EW'(exp_q.size()), EW'(0));
   endtask

   task automatic measure_latency(input string name);
      int lat;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check(name, EW'(lat), EW'(S));
   endtask

   // Monitor: compare every transferred result against the queue head.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {ovf, cout, y}, '0);
            if ({ovf, cout, y} == '0) begin
               n_pass--;
               $display("FAIL unexpected_result: got a result, required none");
            end
         end else begin
            check("result", {ovf, cout, y}, exp_q.pop_front());
         end
      end
   end

   // Stimulus sequence.
   initial begin
      logic          rdy;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;
      logic          rc;
      logic          rs;
      logic [EW-1:0] hold_val;
      logic          any_valid;
      int            not_ready;

      va[0]  = 32'hFFFF_FFFF; vb[0]  = 32'h1;         vc[0]  = 0; vs[0]  = 0; ve[0]  = {1'b0, 1'b1, 32'h0000_0000};
      va[1]  = 32'h5;         vb[1]  = 32'h7;         vc[1]  = 1; vs[1]  = 1; ve[1]  = {1'b0, 1'b0, 32'hFFFF_FFFD};
      va[2]  = 32'h7FFF_FFFF; vb[2]  = 32'h1;         vc[2]  = 0; vs[2]  = 0; ve[2]  = {1'b1, 1'b0, 32'h8000_0000};
      va[3]  = 32'h8000_0000; vb[3]  = 32'h1;         vc[3]  = 0; vs[3]  = 1; ve[3]  = {1'b1, 1'b1, 32'h7FFF_FFFF};
      va[4]  = 32'h8000_0000; vb[4]  = 32'h8000_0000; vc[4]  = 0; vs[4]  = 0; ve[4]  = {1'b1, 1'b1, 32'h0000_0000};
      va[5]  = 32'h0;         vb[5]  = 32'h0;         vc[5]  = 0; vs[5]  = 1; ve[5]  = {1'b0, 1'b1, 32'h0000_0000};
      va[6]  = 32'h0;         vb[6]  = 32'h0;         vc[6]  = 1; vs[6]  = 1; ve[6]  = {1'b0, 1'b0, 32'hFFFF_FFFF};
      va[7]  = 32'h1234_5678; vb[7]  = 32'h1111_1111; vc[7]  = 1; vs[7]  = 0; ve[7]  = {1'b0, 1'b0, 32'h2345_678A};
      va[8]  = 32'hFFFF_FFFF; vb[8]  = 32'hFFFF_FFFF; vc[8]  = 1; vs[8]  = 0; ve[8]  = {1'b0, 1'b1, 32'hFFFF_FFFF};
      va[9]  = 32'h0000_FFFF; vb[9]  = 32'h1;         vc[9]  = 0; vs[9]  = 0; ve[9]  = {1'b0, 1'b0, 32'h0001_0000};
      va[10] = 32'h00FF_FFFF; vb[10] = 32'h0;         vc[10] = 1; vs[10] = 0; ve[10] = {1'b0, 1'b0, 32'h0100_0000};
      va[11] = 32'h10;        vb[11] = 32'h3;         vc[11] = 0; vs[11] = 1; ve[11] = {1'b0, 1'b1, 32'h0000_000D};

      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      #1;
      check("rst_out_valid", EW'(out_valid), EW'(0));
      check("rst_y_cout_ovf", {ovf, cout, y}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready", EW'(in_ready), EW'(1));
      out_ready = 1'b1;

      // Single add with full carry ripple; latency check.
      send(va[0], vb[0], vc[0], vs[0], ve[0], rdy);
      in_valid = 1'b0;
      measure_latency("latency_first");
      wait_drain("drain_t1");

      // Directed vectors back-to-back.
      for (int i = 1; i < NV; i++) send(va[i], vb[i], vc[i], vs[i], ve[i], rdy);
      in_valid = 1'b0;
      wait_drain("drain_directed");

      // Random stream at full rate against the model.
      not_ready = 0;
      for (int i = 0; i < 16; i++) begin
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         send(ra, rb, rc, rs, model(ra, rb, rc, rs), rdy);
         if (!rdy) not_ready++;
      end
      in_valid = 1'b0;
      check("stream_in_ready_misses", EW'(not_ready), EW'(0));
      wait_drain("drain_stream");

      // Backpressure with a full pipe; a rejected junk bundle is offered meanwhile.
      out_ready = 1'b0;
      for (int i = 0; i < S; i++) send(va[i], vb[i], vc[i], vs[i], ve[i], rdy);
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", EW'(out_valid), EW'(1));
      check("bp_in_ready", EW'(in_ready), EW'(0));
      check("bp_head", {ovf, cout, y}, ve[0]);
      hold_val = {ovf, cout, y};
      repeat (5) begin
         @(negedge clk);
         check("bp_hold", {ovf, cout, y}, hold_val);
         check("bp_in_ready_stall", EW'(in_ready), EW'(0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("drain_bp");

      // Reset with three bundles in flight; none of them may appear.
      for (int i = 1; i < 4; i++) send(va[i], vb[i], vc[i], vs[i], ve[i], rdy);
      in_valid = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("flush_out_valid", EW'(out_valid), EW'(0));
      check("flush_y_cout_ovf", {ovf, cout, y}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      any_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         any_valid = any_valid | out_valid;
      end
      check("flush_no_output", EW'(any_valid), EW'(0));
      @(posedge clk);
      #1;
      send(va[7], vb[7], vc[7], vs[7], ve[7], rdy);
      in_valid = 1'b0;
      measure_latency("latency_after_reset");
      wait_drain("drain_final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
